mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port Start  input  1  launch mult/multu/div/divu this cycle.
REQ-006 Port ALUOp  input  4  operation select: aluMult, aluMultU, aluDiv or aluDivU; other codes are no-op.
REQ-007 Port A  input  32  rs operand (multiplicand/dividend).
REQ-008 Port B  input  32  rt operand (multiplier/divisor).
REQ-009 Port HIWrite  input  1  mthi: load HI from A.
REQ-010 Port LOWrite  input  1  mtlo: load LO from A.
REQ-011 Port HIRead  input  1  mfhi: drive HI on Out.
REQ-012 Port LORead  input  1  mflo: drive LO on Out.
REQ-013 Port Busy  output  1  operation in flight.
REQ-014 Port Out  output  32  read data for mfhi/mflo.

Function
REQ-015 Two-state FSM: IDLE, BUSY; counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-016 IDLE + Start + valid ALUOp at edge E0: latch A, B, ALUOp; load counter with N (MULT_CYCLES or DIV_CYCLES); go BUSY.
REQ-017 BUSY: counter decrements each edge; Busy = 1 for exactly N cycles after E0.
REQ-018 At edge EN: HI/LO written with result; FSM to IDLE; Busy = 0 from cycle after EN.
REQ-019 mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit product.
REQ-020 div: LO = signed quotient truncated toward zero; HI = remainder, sign of dividend.
REQ-021 divu: LO = unsigned quotient; HI = unsigned remainder.
REQ-022 Divisor zero (div/divu): full busy latency; HI and LO unchanged at EN.
REQ-023 div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-024 Results computed from latched operands; A/B changes during BUSY have no effect.
REQ-025 Start while BUSY: ignored, in-flight op unaffected.
REQ-026 HIWrite/LOWrite in IDLE: register loaded from A at next edge; both asserted loads both.
REQ-027 HIWrite/LOWrite while BUSY: ignored.
REQ-028 Start and HIWrite/LOWrite same IDLE cycle: Start wins, writes dropped.
REQ-029 Out = HI if HIRead, else LO if LORead, else 0; combinational from HI/LO registers; HIRead has priority.
REQ-030 Out during BUSY reflects pre-operation HI/LO; stalling is the hazard unit's job via Start|Busy.

Reset
REQ-031 reset sampled at edge: HI = 0, LO = 0, counter = 0, FSM = IDLE, Busy = 0.
REQ-032 reset during BUSY aborts op; no result written; reset has priority over Start and writes.

Structure
REQ-033 aluMult, aluMultU, aluDiv, aluDivU come from the shared constant header; no local redefinition.
REQ-034 Single module; no sub-module required; arithmetic via behavioural * and / / % on latched operands.

Verification
REQ-035 mult A=0xFFFFFFFF, B=2 -> Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-037 mthi A=0x12345678 in IDLE, then mfhi -> Out=0x12345678; mthi while BUSY -> HI unchanged.
REQ-038 HI=LO=0xAAAAAAAA, div by B=0 -> after 10 cycles HI=LO=0xAAAAAAAA, Busy=0.
REQ-039 Start mult, reset at busy cycle 3 -> next cycle Busy=0, HI=LO=0; new Start accepted immediately.
REQ-040 Start div, second Start mult with new A/B at busy cycle 2 -> div result only, Busy total 10 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared constants and types for the multiply/divide unit.
// Opcode values are the common ALU encoding used across the pipeline.
package mult_div_unit_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] aluMult  = 4'd8;
  localparam logic [ALU_OP_W-1:0] aluMultU = 4'd9;
  localparam logic [ALU_OP_W-1:0] aluDiv   = 4'd10;
  localparam logic [ALU_OP_W-1:0] aluDivU  = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  // Operands and opcode captured at launch
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } md_req_t;

  function automatic logic is_muldiv_op(input logic [ALU_OP_W-1:0] op);
    return (op == aluMult) || (op == aluMultU) || (op == aluDiv) || (op == aluDivU);
  endfunction

  function automatic logic is_mult_op(input logic [ALU_OP_W-1:0] op);
    return (op == aluMult) || (op == aluMultU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with mthi/mtlo/mfhi/mflo access.
// Result is computed from latched operands and committed on the last busy edge.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Start,
  input  logic [ALU_OP_W-1:0] ALUOp,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic                HIWrite,
  input  logic                LOWrite,
  input  logic                HIRead,
  input  logic                LORead,
  output logic                Busy,
  output logic [DATA_W-1:0]   Out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  md_req_t           req_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              launch, finish;

  logic [DATA_W-1:0]   hi_res, lo_res;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   num, den, quo, rem;
  logic                div_signed, neg_q, neg_r;

  assign launch = (state_q == ST_IDLE) && Start && is_muldiv_op(ALUOp);
  assign finish = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_BUSY;
      ST_BUSY: if (finish) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Busy countdown; reaches zero on the commit edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      req_q <= '0;
    end else if (launch) begin
      cnt_q <= is_mult_op(ALUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      req_q <= '{op: ALUOp, a: A, b: B};
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Signed division via magnitudes avoids the 0x80000000 / -1 overflow case
  always_comb begin
    hi_res     = hi_q;
    lo_res     = lo_q;
    prod       = '0;
    div_signed = (req_q.op == aluDiv);
    neg_q      = div_signed && (req_q.a[DATA_W-1] ^ req_q.b[DATA_W-1]);
    neg_r      = div_signed && req_q.a[DATA_W-1];
    num        = (div_signed && req_q.a[DATA_W-1]) ? DATA_W'(0) - req_q.a : req_q.a;
    den        = (div_signed && req_q.b[DATA_W-1]) ? DATA_W'(0) - req_q.b : req_q.b;
    if (den == '0) den = DATA_W'(1);
    quo = num / den;
    rem = num % den;
    case (req_q.op)
      aluMult: begin
        prod = {{DATA_W{req_q.a[DATA_W-1]}}, req_q.a} * {{DATA_W{req_q.b[DATA_W-1]}}, req_q.b};
        {hi_res, lo_res} = prod;
      end
      aluMultU: begin
        prod = {DATA_W'(0), req_q.a} * {DATA_W'(0), req_q.b};
        {hi_res, lo_res} = prod;
      end
      aluDiv, aluDivU: begin
        if (req_q.b != '0) begin
          lo_res = neg_q ? DATA_W'(0) - quo : quo;
          hi_res = neg_r ? DATA_W'(0) - rem : rem;
        end
      end
      default: ;
    endcase
  end

  // HI/LO: result commit, or mthi/mtlo only when idle and not launching
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (finish) begin
      hi_q <= hi_res;
      lo_q <= lo_res;
    end else if ((state_q == ST_IDLE) && !launch) begin
      if (HIWrite) hi_q <= A;
      if (LOWrite) lo_q <= A;
    end
  end

  assign Busy = (state_q == ST_BUSY);
  assign Out  = HIRead ? hi_q : (LORead ? lo_q : '0);

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against a 64-bit arithmetic model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset, Start, HIWrite, LOWrite, HIRead, LORead, Busy;
  logic [3:0]  ALUOp;
  logic [31:0] A, B, Out;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUOp(ALUOp), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .HIRead(HIRead), .LORead(LORead),
    .Busy(Busy), .Out(Out)
  );

  always #5 clk = ~clk;

  function automatic int exp_cycles(input logic [3:0] op);
    if (op == aluMult || op == aluMultU) return int'(MC);
    if (op == aluDiv || op == aluDivU)   return int'(DC);
    return 0;
  endfunction

  // Reference: plain 64-bit integer arithmetic
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      aluMult:  begin sq = sa * sb; {m_hi, m_lo} = sq; end
      aluMultU: begin up = ua * ub; {m_hi, m_lo} = up; end
      aluDiv:   if (b != 0) begin
                  sq = sa / sb; sr = sa % sb;
                  m_lo = sq[31:0]; m_hi = sr[31:0];
                end
      aluDivU:  if (b != 0) begin
                  up = ua / ub; m_lo = up[31:0];
                  up = ua % ub; m_hi = up[31:0];
                end
      default: ;
    endcase
  endtask

  task automatic read_regs(output logic [31:0] hi, output logic [31:0] lo);
    HIRead = 1'b1; LORead = 1'b0; #1 hi = Out;
    HIRead = 1'b0; LORead = 1'b1; #1 lo = Out;
    LORead = 1'b0; #1;
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi, lo;
    int cyc;
    @(negedge clk); Start = 1'b1; ALUOp = op; A = a; B = b;
    @(negedge clk); Start = 1'b0; A = $urandom; B = $urandom;
    read_regs(hi, lo);
    n_tests++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL %s out_during_busy: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
    end
    cyc = 0;
    while (Busy === 1'b1 && cyc < 64) begin cyc++; @(negedge clk); end
    n_tests++;
    if (cyc != exp_cycles(op)) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, cyc, exp_cycles(op));
    end
    model_op(op, a, b);
    read_regs(hi, lo);
    n_tests++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_fail++;
      $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic write_regs(input logic hw, input logic lw, input logic [31:0] val);
    @(negedge clk); HIWrite = hw; LOWrite = lw; A = val;
    @(negedge clk); HIWrite = 1'b0; LOWrite = 1'b0;
    if (hw) m_hi = val;
    if (lw) m_lo = val;
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_tests++;
    if (Out !== 32'd0) begin n_fail++; $display("FAIL reset_out_noread: got %h want 0", Out); end
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
    end
  endtask

  task automatic test_directed;
    logic [31:0] hi, lo;
    run_op("mult", aluMult, 32'hFFFF_FFFF, 32'd2);
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL mult_const: got %h_%h want ffffffff_fffffffe", hi, lo);
    end
    run_op("multu", aluMultU, 32'hFFFF_FFFF, 32'd2);
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL multu_const: got %h_%h want 00000001_fffffffe", hi, lo);
    end
    run_op("div", aluDiv, 32'hFFFF_FFF9, 32'd2);
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_const: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
    end
    run_op("divu", aluDivU, 32'd7, 32'd2);
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      n_fail++; $display("FAIL divu_const: got hi=%h lo=%h want 1/3", hi, lo);
    end
    run_op("div_ovf", aluDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      n_fail++; $display("FAIL div_ovf_const: got hi=%h lo=%h want 0/80000000", hi, lo);
    end
  endtask

  task automatic test_hilo_access;
    logic [31:0] hi, lo;
    int cyc;
    write_regs(1'b1, 1'b0, 32'h1234_5678);
    HIRead = 1'b1; LORead = 1'b1; #1;
    n_tests++;
    if (Out !== 32'h1234_5678) begin n_fail++; $display("FAIL mfhi_priority: got %h want 12345678", Out); end
    HIRead = 1'b0; LORead = 1'b0;
    write_regs(1'b1, 1'b1, 32'h0BAD_F00D);
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'h0BAD_F00D || lo !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL mthi_mtlo_both: got hi=%h lo=%h want 0badf00d", hi, lo);
    end
    // writes while busy must be dropped
    @(negedge clk); Start = 1'b1; ALUOp = aluMult; A = 32'd3; B = 32'd4;
    @(negedge clk); Start = 1'b0; HIWrite = 1'b1; LOWrite = 1'b1; A = 32'hDEAD_BEEF;
    @(negedge clk); HIWrite = 1'b0; LOWrite = 1'b0;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 64) begin cyc++; @(negedge clk); end
    model_op(aluMult, 32'd3, 32'd4);
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      n_fail++; $display("FAIL mthi_while_busy: got hi=%h lo=%h want 0/c", hi, lo);
    end
    // Start wins over same-cycle writes (divide by zero leaves HI/LO intact)
    @(negedge clk); Start = 1'b1; ALUOp = aluDivU; A = 32'h5555_5555; B = 32'd0;
    HIWrite = 1'b1; LOWrite = 1'b1;
    @(negedge clk); Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; #1;
    n_tests++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL start_wins_busy: got %b want 1", Busy); end
    cyc = 0;
    while (Busy === 1'b1 && cyc < 64) begin cyc++; @(negedge clk); end
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      n_fail++; $display("FAIL start_wins_write: got hi=%h lo=%h want 0/c", hi, lo);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] hi, lo;
    write_regs(1'b1, 1'b1, 32'hAAAA_AAAA);
    run_op("div_zero", aluDiv, 32'h1234_5678, 32'd0);
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'hAAAA_AAAA || lo !== 32'hAAAA_AAAA) begin
      n_fail++; $display("FAIL div_zero_const: got hi=%h lo=%h want aaaaaaaa", hi, lo);
    end
    run_op("divu_zero", aluDivU, 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic test_reset_busy;
    logic [31:0] hi, lo;
    int cyc;
    write_regs(1'b1, 1'b1, 32'h7777_7777);
    @(negedge clk); Start = 1'b1; ALUOp = aluMult; A = 32'd100; B = 32'd200;
    @(negedge clk); Start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_abort_busy: got %b want 0", Busy); end
    read_regs(hi, lo);
    n_tests++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_abort_hilo: got hi=%h lo=%h want 0/0", hi, lo);
    end
    Start = 1'b1; ALUOp = aluMultU; A = 32'd6; B = 32'd7;
    @(negedge clk); Start = 1'b0;
    n_tests++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL restart_after_reset: got %b want 1", Busy); end
    cyc = 1;
    @(negedge clk);
    while (Busy === 1'b1 && cyc < 64) begin cyc++; @(negedge clk); end
    model_op(aluMultU, 32'd6, 32'd7);
    read_regs(hi, lo);
    n_tests++;
    if (cyc != int'(MC) || hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("FAIL restart_result: got cyc=%0d lo=%h want cyc=%0d lo=%h", cyc, lo, MC, m_lo);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] hi, lo;
    int cyc;
    @(negedge clk); Start = 1'b1; ALUOp = aluDiv; A = 32'd1000; B = 32'hFFFF_FFFD;
    @(negedge clk); Start = 1'b0;
    cyc = 1;
    @(negedge clk); Start = 1'b1; ALUOp = aluMult; A = 32'd9; B = 32'd9;
    cyc++;
    @(negedge clk); Start = 1'b0;
    while (Busy === 1'b1 && cyc < 64) begin cyc++; @(negedge clk); end
    model_op(aluDiv, 32'd1000, 32'hFFFF_FFFD);
    read_regs(hi, lo);
    n_tests++;
    if (cyc != int'(DC)) begin n_fail++; $display("FAIL b2b_busy: got %0d want %0d", cyc, DC); end
    n_tests++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_fail++; $display("FAIL b2b_result: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
    @(negedge clk); #1;
    n_tests++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_second: got %b want 0", Busy); end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: op = aluMult;
        1: op = aluMultU;
        2: op = aluDiv;
        3: op = aluDivU;
        4: op = 4'($urandom_range(0, 7));
        default: op = 4'($urandom_range(12, 15));
      endcase
      if ($urandom_range(0, 3) == 0)
        write_regs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op("random", op, rand_opnd(), rand_opnd());
    end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; ALUOp = '0; A = '0; B = '0;
    HIWrite = 1'b0; LOWrite = 1'b0; HIRead = 1'b0; LORead = 1'b0;
    m_hi = '0; m_lo = '0;
    test_reset();
    test_directed();
    test_hilo_access();
    test_div_zero();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
